// File: rtl/byte_lane_serializer.sv
// Serializes a 16-bit word into its enabled 8-bit lanes, one byte per handshake.
// Optional macro MSB_FIRST_EN: a two-lane word emits lane 1 before lane 0.
module byte_lane_serializer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_byteena,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [15:0] byte_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds valid and its payload stable until then.
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t      state;
    logic [15:0] word_q;
    logic [1:0]  ben_q;
    logic        accept;
    logic        handshake;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            word_q    <= '0;
            ben_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q <= in_data;
                        ben_q  <= in_byteena;
                        case (in_byteena)
                            2'b01: begin
                                state     <= SEND_LO;
                                out_valid <= 1'b1;
                                out_data  <= in_data[7:0];
                                out_last  <= 1'b1;
                            end
                            2'b10: begin
                                state     <= SEND_HI;
                                out_valid <= 1'b1;
                                out_data  <= in_data[15:8];
                                out_last  <= 1'b1;
                            end
                            2'b11: begin
`ifdef MSB_FIRST_EN
                                state     <= SEND_HI;
                                out_data  <= in_data[15:8];
`else
                                state     <= SEND_LO;
                                out_data  <= in_data[7:0];
`endif
                                out_valid <= 1'b1;
                                out_last  <= 1'b0;
                            end
                            default: begin
                                // An empty word is swallowed without producing a byte.
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                SEND_LO, SEND_HI: begin
                    if (handshake) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (!out_last && ben_q == 2'b11) begin
                            out_last <= 1'b1;
                            if (state == SEND_LO) begin
                                state    <= SEND_HI;
                                out_data <= word_q[15:8];
                            end else begin
                                state    <= SEND_LO;
                                out_data <= word_q[7:0];
                            end
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lane_serializer.sv
// Directed, table-driven bench for byte_lane_serializer (honours MSB_FIRST_EN).
module tb_byte_lane_serializer;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_byteena;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [15:0] byte_cnt;

    byte_lane_serializer dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_byteena (in_byteena),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .byte_cnt   (byte_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ben;
        int          nbytes;
        logic [7:0]  b0;
        logic        b0_last;
        logic [7:0]  b1;
    } vec_t;

    vec_t        vecs[7];
    logic [8:0]  exp_q[$];
    logic [15:0] model_cnt;
    int          n_vec;
    int          n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers one word with out_ready high and scoreboards every emitted byte.
    task automatic apply_vec(input vec_t v);
        logic [8:0] e;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_data    = v.data;
        in_byteena = v.ben;
        out_ready  = 1'b1;
        if (v.nbytes >= 1) exp_q.push_back({v.b0_last, v.b0});
        if (v.nbytes == 2) exp_q.push_back({1'b1, v.b1});
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_data    = 16'($urandom_range(0, 65535));
        in_byteena = 2'($urandom_range(0, 3));
        for (int k = 0; k < v.nbytes; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
            check("out_last", {31'd0, out_last}, {31'd0, e[8]});
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            model_cnt = model_cnt + 16'd1;
        end
        @(negedge clk);
        check("out_valid_idle", {31'd0, out_valid}, 32'd0);
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("byte_cnt", {16'd0, byte_cnt}, {16'd0, model_cnt});
    endtask

    vec_t       wv;
    logic [7:0] first_b;
    logic [7:0] second_b;

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        model_cnt  = 16'd0;
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0;
        in_byteena = 2'b00;
        out_ready  = 1'b0;

`ifdef MSB_FIRST_EN
        vecs[0] = '{16'hA55A, 2'b11, 2, 8'hA5, 1'b0, 8'h5A};
        vecs[4] = '{16'hFF00, 2'b11, 2, 8'hFF, 1'b0, 8'h00};
        vecs[5] = '{16'h8001, 2'b11, 2, 8'h80, 1'b0, 8'h01};
        first_b  = 8'hCA;
        second_b = 8'hFE;
`else
        vecs[0] = '{16'hA55A, 2'b11, 2, 8'h5A, 1'b0, 8'hA5};
        vecs[4] = '{16'hFF00, 2'b11, 2, 8'h00, 1'b0, 8'hFF};
        vecs[5] = '{16'h8001, 2'b11, 2, 8'h01, 1'b0, 8'h80};
        first_b  = 8'hFE;
        second_b = 8'hCA;
`endif
        vecs[1] = '{16'h1234, 2'b01, 1, 8'h34, 1'b1, 8'h00};
        vecs[2] = '{16'hBEEF, 2'b10, 1, 8'hBE, 1'b1, 8'h00};
        vecs[3] = '{16'hDEAD, 2'b00, 0, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{16'h7E81, 2'b10, 1, 8'h7E, 1'b1, 8'h00};

        // reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // stall on the first byte of a two-lane word while in_data churns
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = 16'hA55A;
        in_byteena = 2'b11;
        out_ready  = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_data    = 16'($urandom_range(0, 65535));
            in_byteena = 2'($urandom_range(0, 3));
`ifdef MSB_FIRST_EN
            check("stall_data", {24'd0, out_data}, 32'hA5);
`else
            check("stall_data", {24'd0, out_data}, 32'h5A);
`endif
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_last", {31'd0, out_last}, 32'd0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_cnt", {16'd0, byte_cnt}, {16'd0, model_cnt});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        model_cnt = model_cnt + 16'd1;
        @(negedge clk);
`ifdef MSB_FIRST_EN
        check("stall_second", {24'd0, out_data}, 32'h5A);
`else
        check("stall_second", {24'd0, out_data}, 32'hA5);
`endif
        check("stall_second_last", {31'd0, out_last}, 32'd1);
        @(posedge clk);
        model_cnt = model_cnt + 16'd1;
        @(negedge clk);
        check("stall_done_valid", {31'd0, out_valid}, 32'd0);
        check("stall_done_cnt", {16'd0, byte_cnt}, {16'd0, model_cnt});

        // asynchronous reset between the two bytes of 0xCAFE
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = 16'hCAFE;
        in_byteena = 2'b11;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_first", {24'd0, out_data}, {24'd0, first_b});
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_second", {24'd0, out_data}, {24'd0, second_b});
        out_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_cnt = 16'd0;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_data", {24'd0, out_data}, 32'd0);
        check("async_byte_cnt", {16'd0, byte_cnt}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("aborted_lane", {31'd0, out_valid}, 32'd0);
        end
        check("aborted_cnt", {16'd0, byte_cnt}, 32'd0);

        // counter wrap: preload near the top, then one two-lane word
        @(negedge clk);
        force dut.byte_cnt = 16'hFFFE;
        #1;
        release dut.byte_cnt;
        model_cnt = 16'hFFFE;
        check("preload_cnt", {16'd0, byte_cnt}, 32'hFFFE);
        wv = vecs[0];
        apply_vec(wv);
        check("wrap_cnt", {16'd0, byte_cnt}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
